// File: rtl/gtp_frame_pkg.sv
// Shared GTP framing constants, FSM state type and header check function.
// The transmitter and the matching receivers both import this package.
package gtp_frame_pkg;

    localparam logic [7:0]  K28_5     = 8'hBC;
    localparam logic [7:0]  TAG_DATA  = 8'h55;
    localparam logic [7:0]  TAG_STAT  = 8'hAA;
    localparam logic [31:0] IDLE_WORD = 32'h0000_50BC;
    localparam logic [3:0]  CTL_K0    = 4'b0001;
    localparam logic [3:0]  CTL_D     = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    function automatic logic [7:0] chk(input logic [31:0] p);
        return p[23:16] + p[7:0];
    endfunction

endpackage

// File: rtl/send_frame.sv
// GTP link transmitter: packs data/status words into K28.5-framed header+payload
// frames, with comma idle words between frames to keep the far end aligned.
module send_frame
    import gtp_frame_pkg::*;
#(
    parameter int unsigned IDLE_GAP  = 2,
    parameter bit          STAT_PRIO = 1'b1
) (
    input  logic        tx_clk,
    input  logic        ap_rst,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [31:0] data_word,
    input  logic        stat_valid,
    output logic        stat_ready,
    input  logic [31:0] stat_word,
    output logic [31:0] gtp_txdata,
    output logic [3:0]  gtp_txctl,
    output logic        tx_busy,
    output logic [7:0]  data_seq,
    output logic [31:0] frame_cnt
);

    state_t      state_q, state_d;
    logic [3:0]  gap_q, gap_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  seq_data_q, seq_data_d;
    logic [7:0]  seq_stat_q, seq_stat_d;
    logic [7:0]  data_seq_q, data_seq_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] txdata_q, txdata_d;
    logic [3:0]  txctl_q, txctl_d;
    logic        data_ready_q, data_ready_d;
    logic        stat_ready_q, stat_ready_d;
    logic        busy_q, busy_d;

    logic        acc_data, acc_stat, accept;
    logic [31:0] acc_word;
    logic [7:0]  acc_seq, acc_tag;
    logic        pref_stat;

    assign acc_data = data_valid & data_ready_q;
    assign acc_stat = stat_valid & stat_ready_q;
    assign accept   = acc_data | acc_stat;
    assign acc_word = acc_stat ? stat_word : data_word;
    assign acc_seq  = acc_stat ? (seq_stat_q + 8'd1) : (seq_data_q + 8'd1);
    assign acc_tag  = acc_stat ? TAG_STAT : TAG_DATA;

    // Ready is registered, so it tracks the valids one cycle late; a lone
    // valid from the non-priority source costs one extra idle cycle.
    assign pref_stat = STAT_PRIO ? !(data_valid && !stat_valid)
                                 :  (stat_valid && !data_valid);

    always_ff @(posedge tx_clk) begin
        if (ap_rst) begin
            state_q      <= S_IDLE;
            gap_q        <= '0;
            word_q       <= '0;
            seq_data_q   <= '0;
            seq_stat_q   <= '0;
            data_seq_q   <= '0;
            frame_cnt_q  <= '0;
            txdata_q     <= IDLE_WORD;
            txctl_q      <= CTL_K0;
            data_ready_q <= 1'b0;
            stat_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            word_q       <= word_d;
            seq_data_q   <= seq_data_d;
            seq_stat_q   <= seq_stat_d;
            data_seq_q   <= data_seq_d;
            frame_cnt_q  <= frame_cnt_d;
            txdata_q     <= txdata_d;
            txctl_q      <= txctl_d;
            data_ready_q <= data_ready_d;
            stat_ready_q <= stat_ready_d;
            busy_q       <= busy_d;
        end
    end

    // The cycle that returns to IDLE also carries the last gap idle word, so
    // GAP itself lasts IDLE_GAP-1 cycles and the counter reaches 0 in IDLE.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        word_d      = word_q;
        seq_data_d  = seq_data_q;
        seq_stat_d  = seq_stat_q;
        data_seq_d  = data_seq_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_HDR;
                    word_d  = acc_word;
                    if (acc_stat) begin
                        seq_stat_d = acc_seq;
                    end else begin
                        seq_data_d = acc_seq;
                        data_seq_d = acc_seq;
                    end
                end
            end
            S_HDR: state_d = S_PAY;
            S_PAY: begin
                frame_cnt_d = frame_cnt_q + 32'd1;
                if (IDLE_GAP > 1) begin
                    state_d = S_GAP;
                    gap_d   = 4'(IDLE_GAP - 1);
                end else begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q <= 4'd1) begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        txdata_d     = IDLE_WORD;
        txctl_d      = CTL_K0;
        data_ready_d = 1'b0;
        stat_ready_d = 1'b0;
        busy_d       = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    txdata_d = {acc_seq, chk(acc_word), acc_tag, K28_5};
                    txctl_d  = CTL_K0;
                end
            end
            S_HDR: begin
                txdata_d = word_q;
                txctl_d  = CTL_D;
            end
            default: ;
        endcase
        if (state_d == S_IDLE) begin
            stat_ready_d = pref_stat;
            data_ready_d = !pref_stat;
        end
    end

    assign data_ready = data_ready_q;
    assign stat_ready = stat_ready_q;
    assign gtp_txdata = txdata_q;
    assign gtp_txctl  = txctl_q;
    assign tx_busy    = busy_q;
    assign data_seq   = data_seq_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
